// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM generator: counting mode, FSM state
// and the minimum period accepted in center-aligned mode.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } pwm_state_e;

    localparam int PWM_CENTER_MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_compare_channel.sv
// One PWM channel: active/pending duty registers and a registered comparator
// against the shared period counter.
module pwm_compare_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk_fpga,
    input  logic             reset,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] counter,
    input  logic             load_active,
    input  logic             load_pending,
    input  logic             transfer_pending,
    input  logic             compare_en,
    output logic             pwm
);

    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] pending_duty;

    // A direct load wins over the pending transfer when both land on one edge.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            active_duty  <= '0;
            pending_duty <= '0;
            pwm          <= 1'b0;
        end else begin
            pwm <= compare_en && (counter < active_duty);
            if (load_active) begin
                active_duty <= duty_in;
            end else if (transfer_pending) begin
                active_duty <= pending_duty;
            end
            if (load_pending) begin
                pending_duty <= duty_in;
            end
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared edge/center-aligned period counter, FSM, and
// period/mode/duty shadowing applied at period boundaries.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk_fpga,
    input  logic                      reset,
    input  logic                      i_enable,
    input  logic [WIDTH-1:0]          i_period,
    input  logic                      i_center_mode,
    input  logic [CHANNELS*WIDTH-1:0] i_duty_cycle,
    input  logic                      i_update,
    output logic [CHANNELS-1:0]       o_pwm_out,
    output logic                      o_period_start,
    output logic                      o_update_pending,
    output logic [1:0]                state_dbg
);

    pwm_state_e       state, state_next;
    logic [WIDTH-1:0] counter, counter_next;
    logic [WIDTH-1:0] active_period, pending_period, period_cap;
    pwm_mode_e        active_mode, pending_mode, mode_cap;
    logic             pending_valid;
    logic             running, compare_en, start_run, boundary;
    logic             load_active, load_pending, transfer_pending;

    // Center mode needs P >= 2 so the down-count reaches 1 before wrapping.
    assign mode_cap   = i_center_mode ? PWM_CENTER : PWM_EDGE;
    assign period_cap = (i_center_mode && (i_period < WIDTH'(PWM_CENTER_MIN_PERIOD)))
                        ? WIDTH'(PWM_CENTER_MIN_PERIOD) : i_period;

    assign running    = (state != IDLE);
    assign compare_en = running && i_enable;
    assign start_run  = (state == IDLE) && i_enable;
    assign boundary   = compare_en &&
                        ((active_mode == PWM_CENTER) ? ((state == RUN_DOWN) && (counter == WIDTH'(1)))
                                                     : (counter == active_period));

    assign load_active      = i_update && (!running || boundary);
    assign load_pending     = i_update && running && !boundary;
    assign transfer_pending = pending_valid && (boundary || start_run);

    always_comb begin
        state_next   = state;
        counter_next = counter;
        if (!i_enable) begin
            state_next   = IDLE;
            counter_next = '0;
        end else if ((state == IDLE) || boundary) begin
            state_next   = RUN_UP;
            counter_next = '0;
        end else if ((active_mode == PWM_CENTER) && (state == RUN_DOWN)) begin
            counter_next = counter - WIDTH'(1);
        end else if ((active_mode == PWM_CENTER) && (counter == active_period)) begin
            state_next   = RUN_DOWN;
            counter_next = counter - WIDTH'(1);
        end else begin
            state_next   = RUN_UP;
            counter_next = counter + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            active_period  <= '1;
            active_mode    <= PWM_EDGE;
            pending_period <= '0;
            pending_mode   <= PWM_EDGE;
            pending_valid  <= 1'b0;
            o_period_start <= 1'b0;
        end else begin
            state          <= state_next;
            counter        <= counter_next;
            o_period_start <= (state_next != IDLE) && (counter_next == '0);
            if (load_active) begin
                active_period <= period_cap;
                active_mode   <= mode_cap;
            end else if (transfer_pending) begin
                active_period <= pending_period;
                active_mode   <= pending_mode;
            end
            if (load_pending) begin
                pending_period <= period_cap;
                pending_mode   <= mode_cap;
                pending_valid  <= 1'b1;
            end else if (boundary || start_run) begin
                pending_valid <= 1'b0;
            end
        end
    end

    assign o_update_pending = pending_valid;
    assign state_dbg        = state;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pwm_compare_channel #(.WIDTH(WIDTH)) u_ch (
            .clk_fpga         (clk_fpga),
            .reset            (reset),
            .duty_in          (i_duty_cycle[k*WIDTH +: WIDTH]),
            .counter          (counter),
            .load_active      (load_active),
            .load_pending     (load_pending),
            .transfer_pending (transfer_pending),
            .compare_en       (compare_en),
            .pwm              (o_pwm_out[k])
        );
    end

endmodule
